// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the execute-stage iterative divider.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Quotient reported for a zero divisor; sliced to the operand width at use.
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {partial, dividend} left, subtract divisor if it fits.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] part_i,
    input  logic [DW-1:0] dvd_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW-1:0] part_o,
    output logic [DW-1:0] dvd_o,
    output logic          qbit_o
);

    logic [DW:0]   shifted;
    logic [DW-1:0] diff;

    assign shifted = {part_i, dvd_i[DW-1]};
    // Wrap-around subtract is exact whenever it is selected, since the result is < divisor.
    assign diff    = shifted[DW-1:0] - dvs_i;
    assign qbit_o  = (shifted >= {1'b0, dvs_i});
    assign part_o  = qbit_o ? diff : shifted[DW-1:0];
    assign dvd_o   = {dvd_i[DW-2:0], 1'b0};

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: operand capture, 32-step restoring loop, sign fix-up, stall and annul.
// Optional `DIV_EARLY_OUT_EN finishes in one cycle when |opa| <= |opb|.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic          annul_i,
    input  logic [DW-1:0] opa_i,
    input  logic [DW-1:0] opb_i,
    output logic          div_stall_o,
    output logic          ready_o,
    output logic [DW-1:0] quot_o,
    output logic [DW-1:0] rem_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    part_q, part_d, dvd_q, dvd_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DW-1:0]    quot_q, quot_d, rem_q, rem_d;
    logic             negq_q, negq_d, negr_q, negr_d;

    logic [DW-1:0]    abs_a, abs_b, step_part, step_dvd, quo_nxt, fix_quot, fix_rem;
    logic             step_qbit;

    assign abs_a = (signed_i && opa_i[DW-1]) ? -opa_i : opa_i;
    assign abs_b = (signed_i && opb_i[DW-1]) ? -opb_i : opb_i;

    div_step #(.DW(DW)) u_step (
        .part_i (part_q),
        .dvd_i  (dvd_q),
        .dvs_i  (dvs_q),
        .part_o (step_part),
        .dvd_o  (step_dvd),
        .qbit_o (step_qbit)
    );

    assign quo_nxt  = {quo_q[DW-2:0], step_qbit};
    assign fix_quot = negq_q ? -quo_nxt : quo_nxt;
    assign fix_rem  = negr_q ? -step_part : step_part;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    negq_d = signed_i & (opa_i[DW-1] ^ opb_i[DW-1]);
                    negr_d = signed_i & opa_i[DW-1];
                    dvs_d  = abs_b;
                    dvd_d  = abs_a;
                    part_d = '0;
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (opb_i == '0) begin
                        state_d = DIV_DONE;
                        quot_d  = DIV_ZERO_QUOT[DW-1:0];
                        rem_d   = opa_i;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        state_d = DIV_DONE;
                        quot_d  = '0;
                        rem_d   = opa_i;
                    end else if (abs_a == abs_b) begin
                        state_d = DIV_DONE;
                        quot_d  = negq_d ? '1 : {{(DW-1){1'b0}}, 1'b1};
                        rem_d   = '0;
                    end
`endif
                    else begin
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                part_d = step_part;
                dvd_d  = step_dvd;
                quo_d  = quo_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DW-1)) begin
                    state_d = DIV_DONE;
                    quot_d  = fix_quot;
                    rem_d   = fix_rem;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        // A flush abandons the operation and leaves the last published result untouched.
        if (annul_i) begin
            state_d = DIV_IDLE;
            quot_d  = quot_q;
            rem_d   = rem_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign div_stall_o = !annul_i &&
                         ((state_q == DIV_IDLE && start_i) || state_q == DIV_RUN);
    assign ready_o     = (state_q == DIV_DONE) && !annul_i;
    assign quot_o      = quot_q;
    assign rem_o       = rem_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide-by-zero, annul, back-to-back.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn, start_i, signed_i, annul_i;
    logic [31:0] opa_i, opb_i;
    logic        div_stall_o, ready_o;
    logic [31:0] quot_o, rem_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DW(32), .CNT_W(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .annul_i     (annul_i),
        .opa_i       (opa_i),
        .opb_i       (opb_i),
        .div_stall_o (div_stall_o),
        .ready_o     (ready_o),
        .quot_o      (quot_o),
        .rem_o       (rem_o)
    );

    // Holds start_i until the ready pulse, counting stall cycles; bounded at 100 cycles.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int stalls, output logic got,
                           output logic [31:0] q, output logic [31:0] r);
        @(negedge clk);
        start_i = 1'b1; signed_i = s; opa_i = a; opb_i = b;
        stalls = 0; got = 1'b0; q = '0; r = '0;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (div_stall_o) stalls++;
            if (ready_o) begin
                got = 1'b1; q = quot_o; r = rem_o;
            end else begin
                @(negedge clk);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opa_i = '0; opb_i = '0;
        #12;
        tests++; if (div_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", div_stall_o); end
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
        tests++; if (quot_o !== 32'h0) begin fails++; $display("FAIL reset_quot: got %h expected 0", quot_o); end
        tests++; if (rem_o !== 32'h0) begin fails++; $display("FAIL reset_rem: got %h expected 0", rem_o); end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int st; logic got; logic [31:0] q, r;
        run_div(32'd100, 32'd7, 1'b0, st, got, q, r);
        tests++; if (st !== 33) begin fails++; $display("FAIL udiv_stalls: got %0d expected 33", st); end
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL udiv_ready: got %b expected 1", got); end
        tests++; if (q !== 32'd14) begin fails++; $display("FAIL udiv_quot: got %h expected %h", q, 32'd14); end
        tests++; if (r !== 32'd2) begin fails++; $display("FAIL udiv_rem: got %h expected %h", r, 32'd2); end
    endtask

    task automatic test_signed;
        int st; logic got; logic [31:0] q, r;
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, st, got, q, r);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL sdiv_ready: got %b expected 1", got); end
        tests++; if (q !== 32'hFFFF_FFFD) begin fails++; $display("FAIL sdiv_quot: got %h expected fffffffd", q); end
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sdiv_rem: got %h expected ffffffff", r); end
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, st, got, q, r);
        tests++; if (q !== 32'h7FFF_FFFC) begin fails++; $display("FAIL udiv_big_quot: got %h expected 7ffffffc", q); end
        tests++; if (r !== 32'd1) begin fails++; $display("FAIL udiv_big_rem: got %h expected 1", r); end
    endtask

    task automatic test_overflow;
        int st; logic got; logic [31:0] q, r;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, st, got, q, r);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL ovf_ready: got %b expected 1", got); end
        tests++; if (st !== 33) begin fails++; $display("FAIL ovf_stalls: got %0d expected 33", st); end
        tests++; if (q !== 32'h8000_0000) begin fails++; $display("FAIL ovf_quot: got %h expected 80000000", q); end
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL ovf_rem: got %h expected 0", r); end
    endtask

    task automatic test_div_zero;
        int st; logic got; logic [31:0] q, r;
        run_div(32'h1234, 32'h0, 1'b1, st, got, q, r);
        tests++; if (st !== 1) begin fails++; $display("FAIL dz_stalls: got %0d expected 1", st); end
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL dz_ready: got %b expected 1", got); end
        tests++; if (q !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_quot: got %h expected ffffffff", q); end
        tests++; if (r !== 32'h1234) begin fails++; $display("FAIL dz_rem: got %h expected 1234", r); end
    endtask

    // Expects the divide-by-zero result to still be on the outputs when it starts.
    task automatic test_annul;
        int st; logic got; logic [31:0] q, r;
        logic saw_ready, saw_stall;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd33;
        repeat (10) @(negedge clk);
        #1;
        tests++; if (div_stall_o !== 1'b1) begin fails++; $display("FAIL annul_pre_stall: got %b expected 1", div_stall_o); end
        annul_i = 1'b1;
        #1;
        tests++; if (div_stall_o !== 1'b0) begin fails++; $display("FAIL annul_stall_drop: got %b expected 0", div_stall_o); end
        tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL annul_ready: got %b expected 0", ready_o); end
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        saw_ready = 1'b0; saw_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready_o) saw_ready = 1'b1;
            if (div_stall_o) saw_stall = 1'b1;
            @(negedge clk);
        end
        tests++; if (saw_ready !== 1'b0) begin fails++; $display("FAIL annul_no_ready: got %b expected 0", saw_ready); end
        tests++; if (saw_stall !== 1'b0) begin fails++; $display("FAIL annul_idle: got %b expected 0", saw_stall); end
        tests++; if (quot_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL annul_quot_hold: got %h expected ffffffff", quot_o); end
        tests++; if (rem_o !== 32'h1234) begin fails++; $display("FAIL annul_rem_hold: got %h expected 1234", rem_o); end
        run_div(32'd1000, 32'd33, 1'b0, st, got, q, r);
        tests++; if (st !== 33) begin fails++; $display("FAIL post_annul_stalls: got %0d expected 33", st); end
        tests++; if (q !== 32'd30) begin fails++; $display("FAIL post_annul_quot: got %h expected %h", q, 32'd30); end
        tests++; if (r !== 32'd10) begin fails++; $display("FAIL post_annul_rem: got %h expected %h", r, 32'd10); end
    endtask

    task automatic test_back_to_back;
        int n, t0, t1;
        logic [31:0] q0, r0, q1, r1;
        n = 0; t0 = 0; t1 = 0; q0 = '0; r0 = '0; q1 = '0; r1 = '0;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd5;
        for (int c = 0; c < 200 && n < 2; c++) begin
            #1;
            if (ready_o) begin
                if (n == 0) begin
                    t0 = c; q0 = quot_o; r0 = rem_o;
                    opa_i = 32'd9; opb_i = 32'd4;
                end else begin
                    t1 = c; q1 = quot_o; r1 = rem_o;
                    start_i = 1'b0;
                end
                n++;
            end
            if (c == 10) opa_i = 32'hDEAD_0000;
            if (n == 1 && c == t0 + 12) opa_i = 32'h0000_BEEF;
            if (n < 2) @(negedge clk);
        end
        start_i = 1'b0;
        tests++; if (n !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", n); end
        tests++; if (t1 - t0 !== 34) begin fails++; $display("FAIL b2b_spacing: got %0d expected 34", t1 - t0); end
        tests++; if (q0 !== 32'd10) begin fails++; $display("FAIL b2b_quot0: got %h expected %h", q0, 32'd10); end
        tests++; if (r0 !== 32'd0) begin fails++; $display("FAIL b2b_rem0: got %h expected 0", r0); end
        tests++; if (q1 !== 32'd2) begin fails++; $display("FAIL b2b_quot1: got %h expected 2", q1); end
        tests++; if (r1 !== 32'd1) begin fails++; $display("FAIL b2b_rem1: got %h expected 1", r1); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_overflow;
        test_div_zero;
        test_annul;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
